// File: rtl/audio_sample_scheduler_pkg.sv
// Shared types, constants and the PCM-to-PWM sample conversion used by the
// audio sample scheduler.
package audio_pkg;

    typedef logic signed [15:0] pcm_t;
    typedef logic [7:0]         pwm_sample_t;

    // Offset-binary zero: the PWM stage idles here (50% duty, silence).
    localparam pwm_sample_t MIDSCALE = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        PLAY
    } sched_state_t;

    // Attenuate by an arithmetic right shift, keep the top byte, then flip
    // its sign bit. XOR with 0x80 is the same as {~v[15], v[14:8]} and maps
    // -32768 -> 0, 0 -> 128, 32767 -> 255.
    function automatic pwm_sample_t pcm_to_pwm(pcm_t pcm, logic [2:0] shift);
        return pwm_sample_t'((pcm >>> shift) >>> 8) ^ MIDSCALE;
    endfunction

endpackage

// File: rtl/audio_sample_scheduler_fifo.sv
// Small show-ahead synchronous FIFO with occupancy output and a synchronous
// flush. Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FULL_LEVEL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Sample storage written on an accepted push.
    // NOTE: the array has no reset; stale words are never visible because level/pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Audio sample scheduler: buffers signed PCM samples, applies volume/mute and
// releases exactly one offset-binary byte to the PWM stage per sample period.
// Start-up priming and underrun hold the output at midscale.
module audio_sample_scheduler #(
    parameter int SAMPLE_DIV  = 2268,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          enable,
    input  logic                          mute,
    input  logic [2:0]                    vol_shift,
    output logic [7:0]                    music_data,
    output logic                          sample_tick,
    output logic [15:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    import audio_pkg::*;

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);

    // Divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_int;

    // Control and output registers
    sched_state_t     state_q, state_d;
    pwm_sample_t      music_q, music_d;
    logic             tick_q, tick_d;
    logic [15:0]      underrun_q, underrun_d;

    // FIFO interface
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [15:0]      fifo_rd;
    logic [LVL_W-1:0] fifo_lvl;
    logic             underrun_evt;

    // Full blocks writes even when a pop lands on the same edge.
    assign s_ready    = enable && !fifo_full;
    assign fifo_push  = s_valid && s_ready;
    // Disabling playback discards queued audio on the very next edge.
    assign fifo_flush = !enable;

    assign tick_int     = enable && (div_q == DIV_LAST);
    assign fifo_pop     = (state_q == PLAY) && tick_int && !fifo_empty;
    assign underrun_evt = (state_q == PLAY) && tick_int &&  fifo_empty;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (s_data),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    // Sample-period divider: free-runs while enabled, parked at zero otherwise.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        div_d = div_q;
        if (!enable) begin
            div_d = '0;
        end else if (tick_int) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Playback state machine: prime the FIFO, play, fall back to priming on underrun.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (fifo_lvl >= PRIME_LVL) state_d = PLAY;
                PLAY:    if (underrun_evt) state_d = PRIME;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output sample, tick pulse and underrun counter; volume and mute matter only at pop time.
    always_comb begin
        music_d    = music_q;
        tick_d     = 1'b0;
        underrun_d = underrun_q;
        if (!enable) begin
            music_d = MIDSCALE;
        end else if (fifo_pop) begin
            tick_d  = 1'b1;
            music_d = mute ? MIDSCALE : pcm_to_pwm(fifo_rd, vol_shift);
        end else if (underrun_evt) begin
            music_d = MIDSCALE;
            if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
        end
    end

    // State register for divider, FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            state_q    <= IDLE;
            music_q    <= MIDSCALE;
            tick_q     <= 1'b0;
            underrun_q <= '0;
        end else begin
            div_q      <= div_d;
            state_q    <= state_d;
            music_q    <= music_d;
            tick_q     <= tick_d;
            underrun_q <= underrun_d;
        end
    end

    assign music_data     = music_q;
    assign sample_tick    = tick_q;
    assign underrun_count = underrun_q;
    assign fifo_level     = fifo_lvl;

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: each accepted sample queues its
// expected PWM byte; a negedge monitor checks every sample_tick against it.
module tb_audio_sample_scheduler;

    import audio_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        enable;
    logic        mute;
    logic [2:0]  vol_shift;
    logic [7:0]  music_data;
    logic        sample_tick;
    logic [15:0] underrun_count;
    logic [4:0]  fifo_level;

    int          checks = 0;
    int          errors = 0;
    int          tick_count = 0;
    logic [7:0]  exp_q [$];

    audio_sample_scheduler #(
        .SAMPLE_DIV  (4),
        .FIFO_DEPTH  (16),
        .PRIME_LEVEL (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .enable         (enable),
        .mute           (mute),
        .vol_shift      (vol_shift),
        .music_data     (music_data),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every output tick must match the oldest queued expectation.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (sample_tick) begin
            tick_count++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got music_data %0d with nothing queued, required no tick", music_data);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_music_data", 32'(music_data), 32'(e));
            end
        end
    end

    // Present one word with s_valid left high; returns just after the accepting edge.
    task automatic push_hold(input logic [15:0] d, input logic [7:0] e);
        bit ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready stayed 0 for word 0x%0h, required acceptance", d);
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(e);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] e);
        push_hold(d, e);
        s_valid = 1'b0;
    endtask

    task automatic wait_tick(output time t);
        bit seen = 1'b0;
        t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sample_tick) begin
                seen = 1'b1;
                t = $time;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no sample_tick in 100 cycles, required one");
        end
    endtask

    // Let queued words play out, then confirm the following tick was an underrun.
    task automatic drain(input logic [15:0] exp_cnt);
        int n = 0;
        int tc;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d words still queued, required 0", exp_q.size());
        end
        tc = tick_count;
        repeat (8) @(negedge clk);
        check("no_tick_on_underrun", 32'(tick_count), 32'(tc));
        check("underrun_count", 32'(underrun_count), 32'(exp_cnt));
        check("underrun_music_midscale", 32'(music_data), 32'd128);
        check("underrun_state_prime", 32'(dut.state_q), 32'(PRIME));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        time t0, t1;
        reset = 1'b1;
        enable = 1'b0;
        mute = 1'b0;
        vol_shift = 3'd0;
        s_valid = 1'b0;
        s_data = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset_music_data", 32'(music_data), 32'd128);
        check("reset_sample_tick", 32'(sample_tick), 32'd0);
        check("reset_underrun_count", 32'(underrun_count), 32'd0);
        check("reset_fifo_level", 32'(fifo_level), 32'd0);
        check("idle_s_ready", 32'(s_ready), 32'd0);
        check("reset_state_idle", 32'(dut.state_q), 32'(IDLE));

        // Priming: one word is not enough, the second starts playback.
        @(posedge clk);
        #1;
        enable = 1'b1;
        push(16'h0000, 8'd128);
        repeat (8) @(negedge clk);
        check("no_tick_before_prime", 32'(tick_count), 32'd0);
        check("prime_fifo_level", 32'(fifo_level), 32'd1);
        @(posedge clk);
        #1;
        push(16'h7FFF, 8'd255);
        wait_tick(t0);
        wait_tick(t1);
        check("tick_spacing_cycles", 32'((t1 - t0) / 10), 32'd4);
        drain(16'd1);

        // Conversion at full scale and with 1-bit attenuation.
        push(16'h8000, 8'd0);
        push(16'h4000, 8'd192);
        drain(16'd2);
        vol_shift = 3'd1;
        push(16'h8000, 8'd64);
        push(16'h7FFF, 8'd191);
        drain(16'd3);
        vol_shift = 3'd0;

        // Mute: output midscale but the FIFO still drains.
        mute = 1'b1;
        push(16'h1234, 8'd128);
        push(16'h8000, 8'd128);
        wait_tick(t0);
        check("mute_level_after_pop1", 32'(fifo_level), 32'd1);
        wait_tick(t0);
        check("mute_level_after_pop2", 32'(fifo_level), 32'd0);
        drain(16'd4);
        mute = 1'b0;

        // Full FIFO back-pressure with s_valid held high.
        for (int i = 1; i <= 40; i++) begin
            push_hold({8'(i), 8'h00}, 8'(i) ^ 8'h80);
            if (fifo_level == 5'd16) break;
        end
        s_data = 16'h5500;
        @(negedge clk);
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_s_ready_low", 32'(s_ready), 32'd0);
        push_hold(16'h5500, 8'hD5);
        check("held_word_level", 32'(fifo_level), 32'd16);
        s_valid = 1'b0;
        drain(16'd5);

        // Counter saturation.
        force dut.underrun_q = 16'hFFFE;
        repeat (2) @(posedge clk);
        #1;
        release dut.underrun_q;
        @(negedge clk);
        check("forced_underrun_count", 32'(underrun_count), 32'hFFFE);
        @(posedge clk);
        #1;
        push(16'h0000, 8'd128);
        push(16'h0000, 8'd128);
        drain(16'hFFFF);
        push(16'h0000, 8'd128);
        push(16'h0000, 8'd128);
        drain(16'hFFFF);

        // Reset mid-PLAY with 10 words queued.
        for (int i = 1; i <= 40; i++) begin
            push_hold({8'(i + 64), 8'h00}, 8'(i + 64) ^ 8'h80);
            if (fifo_level == 5'd10) break;
        end
        s_valid = 1'b0;
        check("queued_before_reset", 32'(fifo_level), 32'd10);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("reset_flush_level", 32'(fifo_level), 32'd0);
        check("reset_flush_music", 32'(music_data), 32'd128);
        check("reset_clears_count", 32'(underrun_count), 32'd0);
        reset = 1'b0;
        push(16'h2000, 8'd160);
        push(16'hE000, 8'd96);
        drain(16'd1);

        // Drop enable mid-PLAY with 10 words queued.
        for (int i = 1; i <= 40; i++) begin
            push_hold({8'(i + 100), 8'h00}, 8'(i + 100) ^ 8'h80);
            if (fifo_level == 5'd10) break;
        end
        s_valid = 1'b0;
        check("queued_before_disable", 32'(fifo_level), 32'd10);
        enable = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("disable_flush_level", 32'(fifo_level), 32'd0);
        check("disable_music_midscale", 32'(music_data), 32'd128);
        check("disable_state_idle", 32'(dut.state_q), 32'(IDLE));
        enable = 1'b1;
        push(16'h3000, 8'd176);
        push(16'hD000, 8'd80);
        drain(16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
